// File: rtl/gf2m163_digit_serial_mul_if.sv
// Byte-stream bundle between the host side and the GF(2^163) digit-serial multiplier.
interface gf2m163_digit_serial_mul_if;
  logic       ctr;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [7:0] g_in;
  logic [7:0] po;
  logic       ctro;

  modport master (output ctr, a_in, b_in, g_in, input po, ctro);
  modport slave  (input ctr, a_in, b_in, g_in, output po, ctro);
endinterface

// File: rtl/gf2m163_digit_serial_mul.sv
// GF(2^163) polynomial-basis multiplier, 8-bit digits MSB first:
// P = A*B mod (x^163 + r(x)), operands and r(x) streamed in, product streamed out.
//
// state  | meaning
// S_IDLE | waiting for a ctr 0->1 edge; first digits captured on that edge
// S_LOAD | shifting in remaining A, B and r(x) digits
// S_COMP | one Horner step per B digit: P = P*x^8 + A*b_j (mod F)
// S_OUT  | shifting P out on po, MSB digit first
module gf2m163_digit_serial_mul (
  input  logic                         clk,
  input  logic                         rstn,
  gf2m163_digit_serial_mul_if.slave    bus
);

  localparam int M   = 163;
  localparam int DW  = 8;
  localparam int ND  = 21;
  localparam int LAT = 42;
  localparam int FW  = ND * DW;
  localparam int PAD = FW - M;
  localparam int GW  = M - DW;
  localparam int OW  = (ND - 1) * DW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_OUT} state_t;

  state_t         state;
  logic [4:0]     cnt;
  logic           ctr_q;
  logic [DW-1:0]  b_prev;
  logic [LAT-1:0] dly;
  logic [M-1:0]   a_sh;
  logic [FW-1:0]  b_sh;
  logic [GW-1:0]  g_sh;
  logic [M-1:0]   acc;
  logic [OW-1:0]  o_sh;
  logic [DW-1:0]  po_q;

  logic [M-1:0]   r_tail;
  logic [DW-1:0]  b_dig;
  logic           last_dig;
  logic [M-1:0]   hz;
  logic [M-1:0]   acc_next;

  assign r_tail   = {{(M-GW){1'b0}}, g_sh};
  assign b_dig    = b_sh[FW-1 -: DW];
  assign last_dig = (cnt == 5'd0);

  // The final digit carries only 3 coefficient bits; its padding bits are skipped
  // so the accumulated shift totals exactly x^163 over the frame.
  always_comb begin
    hz = acc;
    for (int i = DW - 1; i >= 0; i--) begin
      if (!(last_dig && (i < PAD))) begin
        hz = {hz[M-2:0], 1'b0} ^ (hz[M-1] ? r_tail : '0) ^ (b_dig[i] ? a_sh : '0);
      end
    end
    acc_next = hz;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctr_q  <= 1'b0;
      b_prev <= '0;
      dly    <= '0;
    end else begin
      ctr_q  <= bus.ctr;
      b_prev <= bus.b_in;
      dly    <= {dly[LAT-2:0], bus.ctr};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      g_sh  <= '0;
      acc   <= '0;
      o_sh  <= '0;
      po_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          po_q <= '0;
          if (bus.ctr && !ctr_q) begin
            // B digit 0 arrived one cycle ahead of the frame edge
            a_sh  <= {{(M-DW){1'b0}}, bus.a_in};
            b_sh  <= {{(FW-2*DW){1'b0}}, b_prev, bus.b_in};
            g_sh  <= {{(GW-DW){1'b0}}, bus.g_in};
            acc   <= '0;
            cnt   <= 5'(ND - 2);
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt == 5'd0) begin
            a_sh  <= {a_sh[M-(DW-PAD)-1:0], bus.a_in[DW-1:PAD]};
            cnt   <= 5'(ND - 1);
            state <= S_COMP;
          end else begin
            a_sh <= {a_sh[M-DW-1:0], bus.a_in};
            b_sh <= {b_sh[FW-DW-1:0], bus.b_in};
            if (cnt == 5'd1) begin
              g_sh <= {g_sh[GW-(DW-PAD)-1:0], bus.g_in[DW-1:PAD]};
            end else begin
              g_sh <= {g_sh[GW-DW-1:0], bus.g_in};
            end
            cnt <= cnt - 5'd1;
          end
        end
        S_COMP: begin
          acc  <= acc_next;
          b_sh <= b_sh << DW;
          if (cnt == 5'd0) begin
            po_q  <= acc_next[M-1 -: DW];
            o_sh  <= {acc_next[M-DW-1:0], {PAD{1'b0}}};
            cnt   <= 5'(ND - 1);
            state <= S_OUT;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_OUT: begin
          if (cnt != 5'd0) begin
            po_q <= o_sh[OW-1 -: DW];
            o_sh <= o_sh << DW;
            cnt  <= cnt - 5'd1;
          end else begin
            po_q  <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.po   = po_q;
  assign bus.ctro = dly[LAT-1];

endmodule

// File: tb/tb_gf2m163_digit_serial_mul.sv
// Directed and random frame bench for gf2m163_digit_serial_mul.
module tb_gf2m163_digit_serial_mul;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  gf2m163_digit_serial_mul_if bus();

  gf2m163_digit_serial_mul dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] rnd8();
    logic [31:0] t;
    t = $urandom();
    return t[7:0];
  endfunction

  function automatic logic [167:0] rnd168();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[167:0];
  endfunction

  // LSB-first shift-and-add reference over the 163 coefficient bits
  function automatic logic [167:0] gf_ref(input logic [167:0] a, input logic [167:0] b,
                                          input logic [167:0] g);
    logic [162:0] x, y, r, p;
    x = a[167:5];
    y = b[167:5];
    r = g[167:5];
    p = '0;
    for (int i = 0; i < 163; i++) begin
      if (y[i]) p = p ^ x;
      x = x[162] ? ({x[161:0], 1'b0} ^ r) : {x[161:0], 1'b0};
    end
    return {p, 5'b0};
  endfunction

  task automatic check(input string tag, input int c, input logic [167:0] obs,
                       input logic [167:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ctr  = 1'b0;
      bus.a_in = rnd8();
      bus.b_in = rnd8();
      bus.g_in = rnd8();
      @(posedge clk);
      #1;
    end
  endtask

  // Drives edges F-1..F+71 (ctr low only at F-1) and checks po/ctro at each edge.
  task automatic run_frame(input string tag, input logic [167:0] a, input logic [167:0] b,
                           input logic [167:0] g, input logic [167:0] pexp,
                           input bit b2b, input int abort_c);
    logic [7:0] exp_po;
    logic       exp_ctro;
    for (int c = -1; c <= 71; c++) begin
      bus.ctr = (c >= 0);
      if (c == -1)     bus.b_in = b[167:160];
      else if (c <= 19) bus.b_in = b[159-8*c -: 8];
      else             bus.b_in = rnd8();
      if (c >= 0 && c <= 20) bus.a_in = a[167-8*c -: 8];
      else                   bus.a_in = rnd8();
      if (c >= 0 && c <= 19) bus.g_in = g[159-8*c -: 8];
      else                   bus.g_in = rnd8();
      if (c == abort_c) begin
        rstn = 1'b0;
        #1;
        check({tag, "_rst_po"}, c, {160'b0, bus.po}, 168'h0);
        check({tag, "_rst_ctro"}, c, {167'b0, bus.ctro}, 168'h0);
        return;
      end
      @(negedge clk);
      if (c >= 42 && c <= 62) exp_po = pexp[167-8*(c-42) -: 8];
      else                    exp_po = 8'h00;
      if (c >= 42)      exp_ctro = 1'b1;
      else if (c == 41) exp_ctro = 1'b0;
      else              exp_ctro = b2b;
      check({tag, "_po"}, c, {160'b0, bus.po}, {160'b0, exp_po});
      check({tag, "_ctro"}, c, {167'b0, bus.ctro}, {167'b0, exp_ctro});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [167:0] b1, ra, rb, rg;
    rstn     = 1'b0;
    bus.ctr  = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.g_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_po", 0, {160'b0, bus.po}, 168'h0);
    check("reset_ctro", 0, {167'b0, bus.ctro}, 168'h0);
    rstn = 1'b1;
    idle(50);

    b1 = 168'h0123456789abcdef0123456789abcdef0123456789;
    b1[4:0] = 5'b0;
    run_frame("ident",   168'h20, b1, 168'h1920, b1, 1'b0, -100);
    run_frame("reduce",  {1'b1, 167'b0}, 168'h40, 168'h1920, 168'h1920, 1'b1, -100);
    run_frame("reduce8", {1'b1, 167'b0}, 168'h2000, 168'h1920, 168'hC9000, 1'b1, -100);
    run_frame("zero_a",  168'h0, b1, 168'h1920, 168'h0, 1'b1, -100);
    run_frame("pad_a",   168'h3F, 168'h20, 168'h1920, 168'h20, 1'b1, -100);
    run_frame("pad_b",   168'h20, 168'h3F, 168'h1920, 168'h20, 1'b1, -100);

    for (int n = 0; n < 40; n++) begin
      ra = rnd168();
      rb = rnd168();
      if (n % 2 == 0) begin
        rg = 168'h1920;
      end else begin
        rg = rnd168();
        rg[167:160] = 8'h00;
      end
      run_frame("rand", ra, rb, rg, gf_ref(ra, rb, rg), 1'b1, -100);
    end

    ra = rnd168();
    rb = rnd168();
    run_frame("abort", ra, rb, 168'h1920, gf_ref(ra, rb, 168'h1920), 1'b1, 30);
    bus.ctr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(50);
    ra = rnd168();
    rb = rnd168();
    run_frame("post_rst", ra, rb, 168'h1920, gf_ref(ra, rb, 168'h1920), 1'b0, -100);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
